fir_coeff_ctrl: RTL and testbench

Coefficient configuration controller that sits between the sample source and the 10-tap FIR (FIRV3 family).
- Accepts coefficient writes over a narrow valid/ready config port into a shadow bank.
- On commit, gates input samples until in-flight samples have drained through the FIR pipeline.
- Then atomically swaps the shadow bank into the active coefficient outputs that drive C0..C9.
- Forwards DIN/VIN to the FIR, registered, in normal operation.

---
 rtl/fir_coeff_ctrl.sv | 152 +++++++++++++++
 tb/tb_fir_coeff_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_ctrl.sv
// Coefficient configuration controller for the 10-tap FIR: shadow-bank writes,
// drain-gated commit, and an atomic swap into the active coefficient outputs.
module fir_coeff_ctrl #(
    parameter int unsigned NB        = 11,
    parameter int unsigned NTAPS     = 10,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  CFG_VALID,
    output logic                  CFG_READY,
    input  logic [IDX_W-1:0]      CFG_IDX,
    input  logic [NB-1:0]         CFG_DATA,
    input  logic                  CFG_COMMIT,
    input  logic [NB-1:0]         DIN_S,
    input  logic                  VIN_S,
    output logic [NB-1:0]         DIN,
    output logic                  VIN,
    output logic [NTAPS*NB-1:0]   COEFF_OUT,
    output logic                  BUSY,
    output logic                  CFG_ERR,
    output logic [7:0]            DROP_CNT
);

    localparam int unsigned CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               wr_ok_c;
    logic               wr_bad_c;
    logic               gated_c;
    logic [NB-1:0]      shadow [NTAPS];

    // Next-state, drain counter and write-decode logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_ok_c   = 1'b0;
        wr_bad_c  = 1'b0;
        gated_c   = (state != IDLE);
        case (state)
            IDLE: begin
                if (CFG_VALID) begin
                    if (CFG_IDX < IDX_W'(NTAPS)) begin
                        wr_ok_c = 1'b1;
                    end else begin
                        wr_bad_c = 1'b1;
                    end
                end
                if (CFG_COMMIT) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = CNT_W'(DRAIN_CYC - 1);
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    state_nxt = SWAP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            SWAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and drain counter registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Handshake/status outputs, registered from the upcoming state
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            CFG_READY <= 1'b1;
            BUSY      <= 1'b0;
            CFG_ERR   <= 1'b0;
        end else begin
            CFG_READY <= (state_nxt == IDLE);
            BUSY      <= (state_nxt != IDLE);
            CFG_ERR   <= wr_bad_c;
        end
    end

    // Sample forwarding; gated while draining or swapping
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            DIN <= '0;
            VIN <= 1'b0;
        end else begin
            VIN <= VIN_S & ~gated_c;
            if (VIN_S && !gated_c) begin
                DIN <= DIN_S;
            end
        end
    end

    // Saturating count of samples discarded while gated
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            DROP_CNT <= '0;
        end else if (gated_c && VIN_S && (DROP_CNT != 8'hFF)) begin
            DROP_CNT <= DROP_CNT + 8'd1;
        end
    end

    // Shadow bank writes
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < int'(NTAPS); i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NTAPS); i++) begin
                if (wr_ok_c && (CFG_IDX == IDX_W'(i))) begin
                    shadow[i] <= CFG_DATA;
                end
            end
        end
    end

    // Active bank: all taps replaced together in the swap cycle
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            COEFF_OUT <= '0;
        end else if (state == SWAP) begin
            for (int i = 0; i < int'(NTAPS); i++) begin
                COEFF_OUT[i*NB +: NB] <= shadow[i];
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Self-checking bench for fir_coeff_ctrl: event-level reference model,
// per-cycle compare process, and hand-computed pinned expectations.
module tb_fir_coeff_ctrl;

    localparam int unsigned NB        = 11;
    localparam int unsigned NTAPS     = 10;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned DRAIN_CYC = 4;
    localparam int unsigned CW        = NTAPS * NB;

    logic               CLK = 1'b0;
    logic               RSTn = 1'b1;
    logic               CFG_VALID = 1'b0;
    logic               CFG_READY;
    logic [IDX_W-1:0]   CFG_IDX = '0;
    logic [NB-1:0]      CFG_DATA = '0;
    logic               CFG_COMMIT = 1'b0;
    logic [NB-1:0]      DIN_S = '0;
    logic               VIN_S = 1'b0;
    logic [NB-1:0]      DIN;
    logic               VIN;
    logic [CW-1:0]      COEFF_OUT;
    logic               BUSY;
    logic               CFG_ERR;
    logic [7:0]         DROP_CNT;

    always #5 CLK = ~CLK;

    fir_coeff_ctrl #(
        .NB(NB), .NTAPS(NTAPS), .IDX_W(IDX_W), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .CLK(CLK), .RSTn(RSTn),
        .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
        .CFG_IDX(CFG_IDX), .CFG_DATA(CFG_DATA), .CFG_COMMIT(CFG_COMMIT),
        .DIN_S(DIN_S), .VIN_S(VIN_S), .DIN(DIN), .VIN(VIN),
        .COEFF_OUT(COEFF_OUT), .BUSY(BUSY), .CFG_ERR(CFG_ERR), .DROP_CNT(DROP_CNT)
    );

    // Reference model: after a commit the next DRAIN_CYC+1 edges are gated,
    // and the last gated edge copies the shadow bank into the active bank.
    int             gate;
    logic [NB-1:0]  sh  [NTAPS];
    logic [NB-1:0]  act [NTAPS];
    logic [NB-1:0]  m_din;
    logic           m_vin;
    logic           m_err;
    int             m_drop;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            gate   = 0;
            m_din  = '0;
            m_vin  = 1'b0;
            m_err  = 1'b0;
            m_drop = 0;
            for (int i = 0; i < int'(NTAPS); i++) begin
                sh[i]  = '0;
                act[i] = '0;
            end
        end else begin
            m_err = 1'b0;
            if (gate == 0) begin
                m_vin = VIN_S;
                if (VIN_S) m_din = DIN_S;
                if (CFG_VALID) begin
                    if (int'(CFG_IDX) < int'(NTAPS)) sh[CFG_IDX] = CFG_DATA;
                    else m_err = 1'b1;
                end
                if (CFG_COMMIT) gate = int'(DRAIN_CYC) + 1;
            end else begin
                m_vin = 1'b0;
                if (VIN_S && m_drop < 255) m_drop++;
                gate--;
                if (gate == 0) begin
                    for (int i = 0; i < int'(NTAPS); i++) act[i] = sh[i];
                end
            end
        end
    end

    // Pinned literal expectations, posted by the stimulus process
    int             pin_seq = 0;
    bit             pin_din_en;
    logic [NB-1:0]  pin_din;
    bit             pin_coeff_en;
    logic [CW-1:0]  pin_coeff;
    bit             pin_drop_en;
    logic [7:0]     pin_drop;
    bit             started = 1'b0;

    int             n_cmp = 0;
    int             n_bad = 0;
    int             pin_done = 0;
    logic [CW-1:0]  ev;

    task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Compare process: every output against the model on each falling edge
    always @(negedge CLK) begin
        if (started) begin
            for (int i = 0; i < int'(NTAPS); i++) ev[i*NB +: NB] = act[i];
            chk("coeff",    COEFF_OUT,           ev);
            chk("din",      CW'(DIN),            CW'(m_din));
            chk("vin",      CW'(VIN),            CW'(m_vin));
            chk("ready",    CW'(CFG_READY),      CW'(gate == 0));
            chk("busy",     CW'(BUSY),           CW'(gate != 0));
            chk("cfg_err",  CW'(CFG_ERR),        CW'(m_err));
            chk("drop_cnt", CW'(DROP_CNT),       CW'(m_drop));
            if (pin_seq != pin_done) begin
                pin_done = pin_seq;
                if (pin_din_en) begin
                    chk("pin_din", CW'(DIN), CW'(pin_din));
                    chk("pin_vin", CW'(VIN), CW'(1'b1));
                end
                if (pin_coeff_en) chk("pin_coeff", COEFF_OUT, pin_coeff);
                if (pin_drop_en)  chk("pin_drop",  CW'(DROP_CNT), CW'(pin_drop));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic pin(input bit de, input logic [NB-1:0] d,
                       input bit ce, input logic [CW-1:0] c,
                       input bit re, input logic [7:0] r);
        pin_din_en   = de;
        pin_din      = d;
        pin_coeff_en = ce;
        pin_coeff    = c;
        pin_drop_en  = re;
        pin_drop     = r;
        pin_seq++;
    endtask

    task automatic wr(input int idx, input logic [NB-1:0] d);
        CFG_VALID = 1'b1;
        CFG_IDX   = IDX_W'(idx);
        CFG_DATA  = d;
        tick();
        CFG_VALID = 1'b0;
    endtask

    task automatic commit();
        CFG_COMMIT = 1'b1;
        tick();
        CFG_COMMIT = 1'b0;
    endtask

    logic [CW-1:0] exp2, exp3, exp5;

    initial begin
        // Power-up reset, short stream, then reset asserted mid-stream
        #2 RSTn = 1'b0;
        started = 1'b1;
        tick();
        RSTn = 1'b1;
        VIN_S = 1'b1;
        for (int k = 0; k < 3; k++) begin
            DIN_S = NB'(k + 1);
            tick();
        end
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        VIN_S = 1'b1;
        DIN_S = 11'h155;
        tick();
        pin(1'b1, 11'h155, 1'b1, '0, 1'b1, 8'd0);

        // Full load and commit with samples streaming
        for (int i = 0; i < int'(NTAPS); i++) begin
            wr(i, NB'(16 + i));
            exp2[i*NB +: NB] = NB'(16 + i);
        end
        commit();
        repeat (5) tick();
        pin(1'b0, '0, 1'b1, exp2, 1'b1, 8'd5);
        tick();

        // Write and commit in the same cycle
        exp3 = exp2;
        exp3[3*NB +: NB] = 11'h7FF;
        CFG_VALID = 1'b1;
        CFG_IDX = 4'd3;
        CFG_DATA = 11'h7FF;
        CFG_COMMIT = 1'b1;
        tick();
        CFG_VALID = 1'b0;
        CFG_COMMIT = 1'b0;
        repeat (5) tick();
        pin(1'b0, '0, 1'b1, exp3, 1'b1, 8'd10);

        // Out-of-range writes leave every tap untouched
        wr(10, 11'h2AA);
        wr(15, 11'h555);
        commit();
        repeat (5) tick();
        pin(1'b0, '0, 1'b1, exp3, 1'b1, 8'd15);

        // Second commit during drain is ignored
        exp5 = exp3;
        exp5[0 +: NB] = 11'h123;
        wr(0, 11'h123);
        commit();
        tick();
        CFG_COMMIT = 1'b1;
        tick();
        CFG_COMMIT = 1'b0;
        repeat (3) tick();
        pin(1'b0, '0, 1'b1, exp5, 1'b0, '0);
        repeat (6) tick();
        pin(1'b0, '0, 1'b1, exp5, 1'b1, 8'd20);

        // Reset in the middle of a drain aborts the swap
        wr(1, 11'h0AA);
        commit();
        tick();
        tick();
        RSTn = 1'b0;
        tick();
        tick();
        RSTn = 1'b1;
        repeat (8) tick();
        pin(1'b0, '0, 1'b1, '0, 1'b1, 8'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            CFG_VALID  = ($urandom_range(0, 3) == 0);
            CFG_IDX    = IDX_W'($urandom_range(0, 15));
            CFG_DATA   = NB'($urandom);
            CFG_COMMIT = ($urandom_range(0, 15) == 0);
            VIN_S      = $urandom_range(0, 1) == 1;
            DIN_S      = NB'($urandom);
            RSTn       = ($urandom_range(0, 499) != 0);
            tick();
        end
        CFG_VALID = 1'b0;
        CFG_COMMIT = 1'b0;
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        tick();

        // Drop counter saturation over 60 commits (300 drops)
        VIN_S = 1'b1;
        repeat (60) begin
            commit();
            repeat (5) tick();
        end
        pin(1'b0, '0, 1'b0, '0, 1'b1, 8'd255);
        repeat (10) tick();
        pin(1'b0, '0, 1'b0, '0, 1'b1, 8'd255);

        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
